// File: rtl/flowstate_ram_mc.sv
`default_nettype none
// ============================================================================
// Module      : flowstate_ram_mc
// Description : Multi-channel flow-state table. NUM_CH lookup channels and a
//               CSR port share one 1R1W RAM; broadcast updates write first.
// Revision    : 1.0  initial release
// ============================================================================
module flowstate_ram_mc #(
    parameter int FLOWSTATE_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_CH          = 2,
    parameter int OPCODE_WIDTH    = 4,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [FLOWSTATE_WIDTH-1:0]   bcd_flowstate_in,
    input  logic [ADDR_WIDTH-1:0]        bcd_addr_in,
    input  logic                         bcd_valid_in,
    input  logic [NUM_CH-1:0]            s_mat_hit,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] s_mat_addr,
    input  logic [NUM_CH-1:0]            s_mat_valid,
    output logic [NUM_CH-1:0]            s_mat_ready,
    output logic                         m_mat_hit,
    output logic [FLOWSTATE_WIDTH-1:0]   m_mat_value,
    output logic [ADDR_WIDTH-1:0]        m_mat_addr,
    output logic [CH_W-1:0]              m_mat_ch,
    output logic                         m_mat_valid,
    input  logic                         m_mat_ready,
    input  logic [ADDR_WIDTH-1:0]        s_mod_addr,
    input  logic [FLOWSTATE_WIDTH-1:0]   s_mod_data,
    input  logic [OPCODE_WIDTH-1:0]      s_mod_opcode,
    input  logic                         s_mod_valid,
    output logic                         s_mod_ready,
    output logic [FLOWSTATE_WIDTH-1:0]   m_mod_bdata,
    output logic                         m_mod_bvalid,
    input  logic                         m_mod_bready
);

    localparam int                    c_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0] c_OP_RD  = OPCODE_WIDTH'(4'hC);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_WR  = OPCODE_WIDTH'(4'hD);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_CLR = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD = OPCODE_WIDTH'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } rmw_state_t;

    logic [FLOWSTATE_WIDTH-1:0] r_mem [c_DEPTH];

    rmw_state_t                 r_state, w_state_nxt;
    logic [CH_W-1:0]            r_rr_ptr;
    logic                       r_fair_csr;
    logic [ADDR_WIDTH-1:0]      r_rmw_addr;
    logic [FLOWSTATE_WIDTH-1:0] r_rmw_old;
    logic [FLOWSTATE_WIDTH-1:0] r_rmw_opnd;

    logic                       w_op_rd, w_op_wr, w_op_clr, w_op_add;
    logic                       w_idle, w_mat_slot_free, w_mod_slot_free;
    logic                       w_any_mat, w_csr_rd_req, w_csr_rd_wins;
    logic                       w_csr_go, w_mat_go, w_contend;
    logic [CH_W-1:0]            w_mat_sel;
    logic [ADDR_WIDTH-1:0]      w_rd_addr;
    logic [FLOWSTATE_WIDTH-1:0] w_rd_word;
    logic                       w_wr_en, w_rmw_commit;
    logic [ADDR_WIDTH-1:0]      w_wr_addr;
    logic [FLOWSTATE_WIDTH-1:0] w_wr_data;

    // First requesting channel at or after the pointer, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_op_rd  = (s_mod_opcode == c_OP_RD);
    assign w_op_wr  = (s_mod_opcode == c_OP_WR);
    assign w_op_clr = (s_mod_opcode == c_OP_CLR);
    assign w_op_add = (s_mod_opcode == c_OP_ADD);

    assign w_idle          = (r_state == ST_IDLE);
    assign w_mat_slot_free = ~m_mat_valid | m_mat_ready;
    assign w_mod_slot_free = ~m_mod_bvalid | m_mod_bready;

    // Read-port arbitration: fairness bit only matters when both sides ask.
    assign w_any_mat     = w_mat_slot_free & (|s_mat_valid);
    assign w_csr_rd_req  = s_mod_valid & w_idle & (w_op_rd | w_op_add) & w_mod_slot_free;
    assign w_csr_rd_wins = ~w_any_mat | r_fair_csr;
    assign w_csr_go      = w_csr_rd_req & w_csr_rd_wins;
    assign w_mat_go      = w_any_mat & ~(w_csr_rd_req & r_fair_csr);
    assign w_contend     = w_any_mat & w_csr_rd_req;

    assign w_mat_sel   = rr_pick(s_mat_valid, r_rr_ptr);
    assign s_mat_ready = w_mat_go ? (NUM_CH'(1) << w_mat_sel) : '0;
    assign w_rd_addr   = w_mat_go ? s_mat_addr[int'(w_mat_sel)*ADDR_WIDTH +: ADDR_WIDTH]
                                  : s_mod_addr;

    always_comb begin
        s_mod_ready = 1'b0;
        if (!w_idle)
            s_mod_ready = 1'b0;
        else if (w_op_rd || w_op_add)
            s_mod_ready = w_mod_slot_free & w_csr_rd_wins;
        else if (w_op_wr || w_op_clr)
            s_mod_ready = ~bcd_valid_in;
        else
            s_mod_ready = 1'b1;
    end

    // Single write port: broadcast, then the RMW write-back, then CSR D/E.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_addr    = bcd_addr_in;
        w_wr_data    = bcd_flowstate_in;
        w_rmw_commit = 1'b0;
        if (bcd_valid_in) begin
            w_wr_en = 1'b1;
        end else if (r_state == ST_WR) begin
            w_wr_en      = 1'b1;
            w_wr_addr    = r_rmw_addr;
            w_wr_data    = r_rmw_old + r_rmw_opnd;
            w_rmw_commit = 1'b1;
        end else if (s_mod_valid && s_mod_ready && (w_op_wr || w_op_clr)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = s_mod_addr;
            w_wr_data = w_op_wr ? s_mod_data : '0;
        end
    end

    assign w_rd_word = (w_wr_en && (w_wr_addr == w_rd_addr)) ? w_wr_data : r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= w_wr_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_csr_go && w_op_add) w_state_nxt = ST_RD;
            ST_RD:   w_state_nxt = ST_WR;
            ST_WR:   if (w_rmw_commit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_fair_csr <= 1'b0;
            r_rmw_addr <= '0;
            r_rmw_old  <= '0;
            r_rmw_opnd <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mat_go)
                r_rr_ptr <= (w_mat_sel == CH_W'(NUM_CH-1)) ? '0 : w_mat_sel + 1'b1;
            if (w_contend)
                r_fair_csr <= ~r_fair_csr;
            if (w_csr_go && w_op_add) begin
                r_rmw_addr <= s_mod_addr;
                r_rmw_opnd <= s_mod_data;
                r_rmw_old  <= w_rd_word;
            end else if (!w_idle && bcd_valid_in && (bcd_addr_in == r_rmw_addr)) begin
                // A broadcast overtaking the add becomes the new base value.
                r_rmw_old <= bcd_flowstate_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mat_valid  <= 1'b0;
            m_mat_hit    <= 1'b0;
            m_mat_value  <= '0;
            m_mat_addr   <= '0;
            m_mat_ch     <= '0;
            m_mod_bvalid <= 1'b0;
            m_mod_bdata  <= '0;
        end else begin
            if (w_mat_go) begin
                m_mat_valid <= 1'b1;
                m_mat_hit   <= s_mat_hit[w_mat_sel];
                m_mat_value <= w_rd_word;
                m_mat_addr  <= w_rd_addr;
                m_mat_ch    <= w_mat_sel;
            end else if (m_mat_ready) begin
                m_mat_valid <= 1'b0;
            end
            if (w_csr_go) begin
                m_mod_bvalid <= 1'b1;
                m_mod_bdata  <= w_rd_word;
            end else if (m_mod_bready) begin
                m_mod_bvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flowstate_ram_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_flowstate_ram_mc
// Description : Directed self-checking bench for flowstate_ram_mc.
// Revision    : 1.0  initial release
// ============================================================================
module tb_flowstate_ram_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bcd_flowstate_in;
    logic [9:0]  bcd_addr_in;
    logic        bcd_valid_in;
    logic [1:0]  s_mat_hit;
    logic [19:0] s_mat_addr;
    logic [1:0]  s_mat_valid;
    logic [1:0]  s_mat_ready;
    logic        m_mat_hit;
    logic [31:0] m_mat_value;
    logic [9:0]  m_mat_addr;
    logic [0:0]  m_mat_ch;
    logic        m_mat_valid;
    logic        m_mat_ready;
    logic [9:0]  s_mod_addr;
    logic [31:0] s_mod_data;
    logic [3:0]  s_mod_opcode;
    logic        s_mod_valid;
    logic        s_mod_ready;
    logic [31:0] m_mod_bdata;
    logic        m_mod_bvalid;
    logic        m_mod_bready;

    int n_cmp = 0;
    int n_err = 0;

    flowstate_ram_mc dut (
        .clk(clk), .rst_n(rst_n),
        .bcd_flowstate_in(bcd_flowstate_in), .bcd_addr_in(bcd_addr_in), .bcd_valid_in(bcd_valid_in),
        .s_mat_hit(s_mat_hit), .s_mat_addr(s_mat_addr), .s_mat_valid(s_mat_valid),
        .s_mat_ready(s_mat_ready), .m_mat_hit(m_mat_hit), .m_mat_value(m_mat_value),
        .m_mat_addr(m_mat_addr), .m_mat_ch(m_mat_ch), .m_mat_valid(m_mat_valid),
        .m_mat_ready(m_mat_ready), .s_mod_addr(s_mod_addr), .s_mod_data(s_mod_data),
        .s_mod_opcode(s_mod_opcode), .s_mod_valid(s_mod_valid), .s_mod_ready(s_mod_ready),
        .m_mod_bdata(m_mod_bdata), .m_mod_bvalid(m_mod_bvalid), .m_mod_bready(m_mod_bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a CSR request until accepted; returns 1 time unit after the accepting edge.
    task automatic csr_req(input logic [3:0] op, input logic [9:0] addr, input logic [31:0] data);
        logic acc;
        acc          = 1'b0;
        s_mod_opcode = op;
        s_mod_addr   = addr;
        s_mod_data   = data;
        s_mod_valid  = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #2;
            acc = s_mod_ready;
            @(posedge clk);
            #1;
        end
        s_mod_valid  = 1'b0;
        s_mod_opcode = 4'h0;
        chk("csr_accept", acc, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bcd_flowstate_in = '0; bcd_addr_in = '0; bcd_valid_in = 1'b0;
        s_mat_hit = '0; s_mat_addr = '0; s_mat_valid = '0;
        m_mat_ready = 1'b1; m_mod_bready = 1'b1;
        s_mod_addr = '0; s_mod_data = '0; s_mod_opcode = '0; s_mod_valid = 1'b0;
        tick(); tick();
        chk("rst_mat_valid", m_mat_valid, 0);
        chk("rst_mod_bvalid", m_mod_bvalid, 0);
        chk("rst_mat_value", m_mat_value, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a held lookup
        m_mat_ready = 1'b0;
        s_mat_valid = 2'b01; s_mat_addr = {10'd0, 10'd0};
        tick();
        chk("pre_rst_mat_valid", m_mat_valid, 1);
        s_mat_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_mat_valid", m_mat_valid, 0);
        chk("midrst_mat_value", m_mat_value, 0);
        chk("midrst_mod_bvalid", m_mod_bvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_mat_ready = 1'b1;
        #2;
        chk("post_rst_mod_ready", s_mod_ready, 1);
        tick();

        // Round-robin between two always-valid channels
        csr_req(4'hD, 10'd7, 32'h0000_0707);
        csr_req(4'hD, 10'd8, 32'h0000_0808);
        s_mat_valid = 2'b11; s_mat_hit = 2'b10; s_mat_addr = {10'd8, 10'd7};
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_ready", s_mat_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            chk("rr_ch", m_mat_ch, i % 2);
            chk("rr_hit", m_mat_hit, i % 2);
            chk("rr_value", m_mat_value, (i % 2 == 0) ? 32'h0707 : 32'h0808);
        end
        s_mat_valid = 2'b00; s_mat_hit = 2'b00;
        tick();

        // Broadcast write forwarded to a same-cycle lookup
        bcd_valid_in = 1'b1; bcd_addr_in = 10'd5; bcd_flowstate_in = 32'h0000_AAAA;
        s_mat_valid = 2'b01; s_mat_addr = {10'd0, 10'd5};
        #2;
        chk("fwd_ready", s_mat_ready, 2'b01);
        @(posedge clk); #1;
        bcd_valid_in = 1'b0; s_mat_valid = 2'b00;
        chk("fwd_valid", m_mat_valid, 1);
        chk("fwd_value", m_mat_value, 32'h0000_AAAA);
        csr_req(4'hC, 10'd5, 32'h0);
        chk("bcd_readback", m_mod_bdata, 32'h0000_AAAA);

        // Read-modify-write add
        csr_req(4'hD, 10'd3, 32'd10);
        csr_req(4'hF, 10'd3, 32'd5);
        chk("add_bvalid", m_mod_bvalid, 1);
        chk("add_bdata", m_mod_bdata, 32'd10);
        csr_req(4'hC, 10'd3, 32'h0);
        chk("add_sum", m_mod_bdata, 32'd15);

        // Broadcast overtakes the add write-back; lookup sees the committed sum
        csr_req(4'hF, 10'd3, 32'd5);
        chk("add2_bdata", m_mod_bdata, 32'd15);
        tick();
        bcd_valid_in = 1'b1; bcd_addr_in = 10'd3; bcd_flowstate_in = 32'd100;
        tick();
        bcd_valid_in = 1'b0;
        s_mat_valid = 2'b01; s_mat_addr = {10'd0, 10'd3};
        tick();
        s_mat_valid = 2'b00;
        chk("wr_fwd_value", m_mat_value, 32'd105);
        csr_req(4'hC, 10'd3, 32'h0);
        chk("add_retry_sum", m_mod_bdata, 32'd105);

        // Held result blocks lookups; CSR traffic proceeds
        m_mat_ready = 1'b0;
        s_mat_valid = 2'b01; s_mat_addr = {10'd0, 10'd5};
        tick();
        s_mat_valid = 2'b11;
        #2;
        chk("held_mat_ready", s_mat_ready, 2'b00);
        @(posedge clk); #1;
        csr_req(4'hC, 10'd3, 32'h0);
        chk("held_csr_bdata", m_mod_bdata, 32'd105);
        csr_req(4'hD, 10'd5, 32'h0000_1234);
        chk("held_snapshot", m_mat_value, 32'h0000_AAAA);
        chk("held_valid", m_mat_valid, 1);
        s_mat_valid = 2'b00; m_mat_ready = 1'b1;
        tick();
        chk("released_valid", m_mat_valid, 0);

        // Add wraps modulo 2^32, then clear
        csr_req(4'hD, 10'd9, 32'hFFFF_FFFF);
        csr_req(4'hF, 10'd9, 32'd2);
        chk("wrap_bdata", m_mod_bdata, 32'hFFFF_FFFF);
        csr_req(4'hC, 10'd9, 32'h0);
        chk("wrap_sum", m_mod_bdata, 32'h0000_0001);
        csr_req(4'hE, 10'd9, 32'h0);
        csr_req(4'hC, 10'd9, 32'h0);
        chk("clear_value", m_mod_bdata, 32'h0);

        // Contention: mat wins first, then CSR
        s_mat_valid = 2'b01; s_mat_addr = {10'd0, 10'd5};
        s_mod_valid = 1'b1; s_mod_opcode = 4'hC; s_mod_addr = 10'd3;
        #2;
        chk("cont1_mat_ready", s_mat_ready, 2'b01);
        chk("cont1_mod_ready", s_mod_ready, 0);
        @(posedge clk); #1;
        chk("cont1_mat_value", m_mat_value, 32'h0000_1234);
        #1;
        chk("cont2_mat_ready", s_mat_ready, 2'b00);
        chk("cont2_mod_ready", s_mod_ready, 1);
        @(posedge clk); #1;
        s_mod_valid = 1'b0; s_mod_opcode = 4'h0; s_mat_valid = 2'b00;
        chk("cont2_bdata", m_mod_bdata, 32'd105);

        // No-op opcode: accepted, no response
        tick();
        csr_req(4'h3, 10'd1, 32'h0);
        chk("noop_bvalid", m_mod_bvalid, 0);

        // Same-cycle broadcast and CSR write to one address
        bcd_valid_in = 1'b1; bcd_addr_in = 10'd20; bcd_flowstate_in = 32'h11;
        s_mod_valid = 1'b1; s_mod_opcode = 4'hD; s_mod_addr = 10'd20; s_mod_data = 32'h22;
        #2;
        chk("bcd_stall_ready", s_mod_ready, 0);
        @(posedge clk); #1;
        bcd_valid_in = 1'b0;
        #2;
        chk("bcd_after_ready", s_mod_ready, 1);
        @(posedge clk); #1;
        s_mod_valid = 1'b0; s_mod_opcode = 4'h0;
        csr_req(4'hC, 10'd20, 32'h0);
        chk("csr_overwrite", m_mod_bdata, 32'h22);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
